l1d_wb_queue: RTL
=================

L1D_WB_QUEUE -- requirements
Module: l1d_wb_queue

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of queue entries; legal values are 4 to 16.
REQ-002 Parameter ADDR_W, default 5, SHALL set the register-address width.
REQ-003 Parameter DATA_W, default 16, SHALL set the writeback data width.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 Port clock_i, input, 1 bit: rising-edge clock.
REQ-006 Port nReset_i, input, 1 bit: asynchronous active-low reset.
REQ-007 Ports wbEnableA_i and wbEnableB_i, input, 1 bit each: writeback request from the L1D ports A and B.
REQ-008 Ports wbAddressA_i and wbAddressB_i, input, ADDR_W bits each: destination register of each request.
REQ-009 Ports wbDataA_i and wbDataB_i, input, DATA_W bits each: data of each request.
REQ-010 Port stall_o, input-side backpressure, output, 1 bit: upstream SHALL NOT present requests while this is high.
REQ-011 Port regWrEnable_o, output, 1 bit: register-file write strobe.
REQ-012 Port regWrAddress_o, output, ADDR_W bits: register-file write address.
REQ-013 Port regWrData_o, output, DATA_W bits: register-file write data.

Function
REQ-014 On every rising edge with stall_o low, the block SHALL accept each enabled request, A before B, because B is the younger request.
REQ-015 When both requests are enabled with equal addresses, the block SHALL accept only B and discard A.
REQ-016 Requests presented while stall_o is high SHALL be ignored and SHALL NOT change any state.
REQ-017 On each edge, the output registers SHALL load the oldest pending entry, including entries accepted at that same edge, so that a request into an empty queue reaches the outputs one cycle after being sampled.
REQ-018 Entries SHALL leave the block at most one per cycle, in strict FIFO order.
REQ-019 When there is no pending entry, the block SHALL drive regWrEnable_o to 0, and regWrAddress_o and regWrData_o SHALL hold their previous values.
REQ-020 The occupancy count SHALL update as count_next = count + accepted - (count + accepted > 0 ? 1 : 0), where accepted is 0, 1 or 2.
REQ-021 stall_o SHALL be a combinational decode of the registered count and SHALL be high when count >= DEPTH-1.
REQ-022 The count SHALL never exceed DEPTH-1.
REQ-023 The read and write pointers SHALL wrap modulo DEPTH.
REQ-024 The block SHALL NOT merge entries already in the queue, so a later write to the same register is delivered after the earlier one.

Reset
REQ-025 Asserting nReset_i SHALL immediately set count, pointers and regWrEnable_o to 0, and regWrAddress_o and regWrData_o to 0.
REQ-026 Reset during operation SHALL discard all pending entries.
REQ-027 After nReset_i deasserts, stall_o SHALL be low.
REQ-028 Entry storage SHALL NOT require reset.

Structure
REQ-029 The default values of ADDR_W and DATA_W, and the opcode constants shared with the L1D, SHALL live in the shared core package.
REQ-030 A single sub-module, wb_fifo_mem, SHALL hold the entry storage, with two write ports and one read port.
REQ-031 The write-index, collapse and count logic SHALL stay in the top module.

Verification
REQ-032 Single request, empty queue: A={r3, 0x1234} -> next cycle regWrEnable_o=1, regWrAddress_o=3, regWrData_o=0x1234; the cycle after, regWrEnable_o=0.
REQ-033 Dual request: A={r1, 0x0011}, B={r2, 0x0022} in one cycle -> r1 is written, then r2 the following cycle, and count peaks at 1.
REQ-034 Collapse: A={r7, 0xAAAA}, B={r7, 0xBBBB} -> only one write, r7=0xBBBB.
REQ-035 Backpressure: dual requests every cycle, DEPTH=4 -> stall_o rises once count=3, requests presented during stall are dropped, and all accepted entries drain in order.
REQ-036 Wrap-around: 20 sequential single requests with data = index -> outputs match index order 0 to 19 with no loss.
REQ-037 Reset mid-drain: count=3, then nReset_i is pulsed low between edges -> regWrEnable_o=0 immediately and stall_o=0; after release, no stale writes appear.

Source files
------------

// File: rtl/l1d_wb_queue_pkg.sv
// Shared core package: writeback widths and L1D opcode constants.
package l1d_wb_queue_pkg;

   // Default register-address and writeback-data widths.
   localparam int unsigned L1D_WB_ADDR_W = 5;
   localparam int unsigned L1D_WB_DATA_W = 16;

   // Queue depth bounds.
   localparam int unsigned L1D_WB_DEPTH_MIN = 4;
   localparam int unsigned L1D_WB_DEPTH_MAX = 16;

   // Opcodes shared with the L1D request path.
   typedef enum logic [1:0] {
      L1D_OP_LOAD  = 2'd0,
      L1D_OP_STORE = 2'd1,
      L1D_OP_AMO   = 2'd2,
      L1D_OP_FLUSH = 2'd3
   } l1d_op_e;

endpackage

// File: rtl/l1d_wb_queue_fifo_mem.sv
// Writeback entry storage: two write ports, one asynchronous read port.
// Storage is not reset; the top-level pointers and count define validity.
module wb_fifo_mem #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned ENT_W = 21,
   parameter int unsigned PTR_W = 2
) (
   input  logic             clock_i,
   input  logic             we0_i,
   input  logic [PTR_W-1:0] waddr0_i,
   input  logic [ENT_W-1:0] wdata0_i,
   input  logic             we1_i,
   input  logic [PTR_W-1:0] waddr1_i,
   input  logic [ENT_W-1:0] wdata1_i,
   input  logic [PTR_W-1:0] raddr_i,
   output logic [ENT_W-1:0] rdata_o
);

   logic [ENT_W-1:0] mem_q [DEPTH];

   // Write both ports; the top guarantees the two indices never collide.
   always_ff @(posedge clock_i) begin
      if (we0_i) mem_q[waddr0_i] <= wdata0_i;
      if (we1_i) mem_q[waddr1_i] <= wdata1_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/l1d_wb_queue.sv
// L1D writeback queue: accepts up to two register writebacks per cycle,
// collapses same-register pairs, and retires one write per cycle in order.
module l1d_wb_queue
   import l1d_wb_queue_pkg::*;
#(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned ADDR_W = L1D_WB_ADDR_W,
   parameter int unsigned DATA_W = L1D_WB_DATA_W
) (
   input  logic              clock_i,
   input  logic              nReset_i,
   input  logic              wbEnableA_i,
   input  logic [ADDR_W-1:0] wbAddressA_i,
   input  logic [DATA_W-1:0] wbDataA_i,
   input  logic              wbEnableB_i,
   input  logic [ADDR_W-1:0] wbAddressB_i,
   input  logic [DATA_W-1:0] wbDataB_i,
   output logic              stall_o,
   output logic              regWrEnable_o,
   output logic [ADDR_W-1:0] regWrAddress_o,
   output logic [DATA_W-1:0] regWrData_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned ENT_W = ADDR_W + DATA_W;
   localparam int unsigned DEPTH_U = DEPTH;
   localparam int unsigned FULL_U  = DEPTH - 1;
   localparam logic [PTR_W:0]   DEPTH_P  = DEPTH_U[PTR_W:0];
   localparam logic [CNT_W-1:0] FULL_LVL = FULL_U[CNT_W-1:0];

   // Pointer advance by 0..2 with wrap modulo DEPTH (DEPTH need not be 2^n).
   function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                                input logic [1:0]       n);
      logic [PTR_W:0] s;
      s = {1'b0, p} + {{(PTR_W-1){1'b0}}, n};
      if (s >= DEPTH_P) s = s - DEPTH_P;
      return s[PTR_W-1:0];
   endfunction

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              wr_en_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [DATA_W-1:0] wr_data_q;

   logic              acc_a, acc_b;
   logic [1:0]        acc_n;
   logic              out_vld;
   logic [PTR_W-1:0]  waddr1;
   logic [ENT_W-1:0]  rdata;
   logic [ENT_W-1:0]  head;
   logic [CNT_W:0]    cnt_sum;

   // Backpressure is a pure decode of the registered count.
   assign stall_o = (count_q >= FULL_LVL);

   // Acceptance: A is dropped when B targets the same register in the
   // same cycle, since B is younger and would overwrite it anyway.
   always_comb begin
      acc_a = wbEnableA_i && !stall_o &&
              !(wbEnableB_i && (wbAddressA_i == wbAddressB_i));
      acc_b = wbEnableB_i && !stall_o;
      acc_n = {1'b0, acc_a} + {1'b0, acc_b};
   end

   // B lands directly after A when both are accepted.
   assign waddr1 = ptr_add(wr_ptr_q, {1'b0, acc_a});

   wb_fifo_mem #(
      .DEPTH (DEPTH),
      .ENT_W (ENT_W),
      .PTR_W (PTR_W)
   ) u_mem (
      .clock_i  (clock_i),
      .we0_i    (acc_a),
      .waddr0_i (wr_ptr_q),
      .wdata0_i ({wbAddressA_i, wbDataA_i}),
      .we1_i    (acc_b),
      .waddr1_i (waddr1),
      .wdata1_i ({wbAddressB_i, wbDataB_i}),
      .raddr_i  (rd_ptr_q),
      .rdata_o  (rdata)
   );

   // Head selection: stored entry if any, else bypass the oldest new request.
   // Bypassed entries are still written to storage so pointers stay aligned.
   always_comb begin
      head    = rdata;
      out_vld = (count_q != '0) || (acc_n != 2'd0);
      if (count_q == '0) begin
         if (acc_a) head = {wbAddressA_i, wbDataA_i};
         else       head = {wbAddressB_i, wbDataB_i};
      end
   end

   // Next-state for pointers and occupancy.
   always_comb begin
      wr_ptr_d = ptr_add(wr_ptr_q, acc_n);
      rd_ptr_d = out_vld ? ptr_add(rd_ptr_q, 2'd1) : rd_ptr_q;
      cnt_sum  = {1'b0, count_q} + {{(CNT_W-1){1'b0}}, acc_n}
                 - {{CNT_W{1'b0}}, out_vld};
      count_d  = cnt_sum[CNT_W-1:0];
   end

   // Queue state and registered write-port outputs; address/data hold when idle.
   always_ff @(posedge clock_i or negedge nReset_i) begin
      if (!nReset_i) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         wr_en_q  <= out_vld;
         if (out_vld) begin
            wr_addr_q <= head[ENT_W-1:DATA_W];
            wr_data_q <= head[DATA_W-1:0];
         end
      end
   end

   assign regWrEnable_o  = wr_en_q;
   assign regWrAddress_o = wr_addr_q;
   assign regWrData_o    = wr_data_q;

endmodule
